// File: rtl/axi_default_slave.sv
// ---------------------------------------------------------------------------
// axi_default_slave
//
// AXI4 default responder. Any read or write burst routed here (address that
// decodes to no mapped slave) is terminated with a DECERR response so that
// the master's handshakes always complete. The write and read channels are
// served by two independent state machines. Addresses, sizes, burst types
// and write data are ignored.
//
// Ports
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   AW*_S                         write address channel (ID latched, rest ignored)
//   W*_S                          write data channel (data discarded, WLAST ends burst)
//   B*_S                          write response channel (always DECERR)
//   AR*_S                         read address channel (ID and LEN latched)
//   R*_S                          read data channel (zero data, DECERR, ARLEN+1 beats)
//   wr_err_cnt / rd_err_cnt       saturating counts of completed DECERR bursts
//
// Every output comes straight from a flop or is constant; no input reaches
// an output combinationally.
// ---------------------------------------------------------------------------
module axi_default_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // write address
  input  logic [ID_W-1:0]     AWID_S,
  input  logic [ADDR_W-1:0]   AWADDR_S,
  input  logic [LEN_W-1:0]    AWLEN_S,
  input  logic [2:0]          AWSIZE_S,
  input  logic [1:0]          AWBURST_S,
  input  logic                AWVALID_S,
  output logic                AWREADY_S,
  // write data
  input  logic [DATA_W-1:0]   WDATA_S,
  input  logic [DATA_W/8-1:0] WSTRB_S,
  input  logic                WLAST_S,
  input  logic                WVALID_S,
  output logic                WREADY_S,
  // write response
  output logic [ID_W-1:0]     BID_S,
  output logic [1:0]          BRESP_S,
  output logic                BVALID_S,
  input  logic                BREADY_S,
  // read address
  input  logic [ID_W-1:0]     ARID_S,
  input  logic [ADDR_W-1:0]   ARADDR_S,
  input  logic [LEN_W-1:0]    ARLEN_S,
  input  logic [2:0]          ARSIZE_S,
  input  logic [1:0]          ARBURST_S,
  input  logic                ARVALID_S,
  output logic                ARREADY_S,
  // read data
  output logic [ID_W-1:0]     RID_S,
  output logic [DATA_W-1:0]   RDATA_S,
  output logic [1:0]          RRESP_S,
  output logic                RLAST_S,
  output logic                RVALID_S,
  input  logic                RREADY_S,
  // debug counters
  output logic [CNT_W-1:0]    wr_err_cnt,
  output logic [CNT_W-1:0]    rd_err_cnt
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  w_state_e         w_state_q;
  logic             awready_q;
  logic             wready_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic [ID_W-1:0]  bid_q;
  logic [CNT_W-1:0] wr_cnt_q;

  // NOTE: the reset branch is asynchronous (in the sensitivity list) and all
  // state updates use non-blocking assignments so every flop samples the
  // pre-edge values of the others.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
      wr_cnt_q  <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          // READY comes up one cycle after reset release and stays up
          // until an address is taken.
          awready_q <= 1'b1;
          if (awready_q && AWVALID_S) begin
            bid_q     <= AWID_S;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          // Beats are swallowed; only the WLAST handshake matters.
          if (wready_q && WVALID_S && WLAST_S) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= RESP_DECERR;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY_S) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  r_state_e         r_state_q;
  logic             arready_q;
  logic             rvalid_q;
  logic             rlast_q;
  logic [1:0]       rresp_q;
  logic [ID_W-1:0]  rid_q;
  logic [LEN_W-1:0] rlen_q;
  logic [LEN_W-1:0] beat_q;
  logic [CNT_W-1:0] rd_cnt_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rlen_q    <= '0;
      beat_q    <= '0;
      rd_cnt_q  <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && ARVALID_S) begin
            rid_q     <= ARID_S;
            rlen_q    <= ARLEN_S;
            beat_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= RESP_DECERR;
            rlast_q   <= (ARLEN_S == '0);
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY_S) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rresp_q   <= 2'b00;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
              if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end else begin
              // RLAST is precomputed for the next beat so it leaves a flop.
              // The counter is never advanced past the last beat, so a
              // 16-beat burst cannot wrap a LEN_W-wide counter.
              beat_q  <= beat_q + LEN_W'(1);
              rlast_q <= ((beat_q + LEN_W'(1)) == rlen_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Ignored request fields, folded together so they are visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, WDATA_S,
                           WSTRB_S, ARADDR_S, ARSIZE_S, ARBURST_S};

  assign AWREADY_S  = awready_q;
  assign WREADY_S   = wready_q;
  assign BVALID_S   = bvalid_q;
  assign BRESP_S    = bresp_q;
  assign BID_S      = bid_q;
  assign ARREADY_S  = arready_q;
  assign RVALID_S   = rvalid_q;
  assign RLAST_S    = rlast_q;
  assign RRESP_S    = rresp_q;
  assign RID_S      = rid_q;
  assign RDATA_S    = '0;
  assign wr_err_cnt = wr_cnt_q;
  assign rd_err_cnt = rd_cnt_q;

endmodule

// File: tb/tb_axi_default_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_default_slave
//
// Directed plus randomized transactions against axi_default_slave. The
// expected behaviour is kept as transaction-level facts: a burst of LEN has
// LEN+1 read beats, only the final one flagged last, every response is
// DECERR with the request's ID, and each finished burst adds one to an
// integer count. A second instance with a 3-bit counter shares all inputs
// so saturation can be reached in a few dozen bursts.
// ---------------------------------------------------------------------------
module tb_axi_default_slave;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // stimulus
  logic [ID_W-1:0]     aw_id = '0;
  logic [ADDR_W-1:0]   aw_addr = '0;
  logic [LEN_W-1:0]    aw_len = '0;
  logic [2:0]          aw_size = 3'd2;
  logic [1:0]          aw_burst = 2'b01;
  logic                aw_valid = 1'b0;
  logic [DATA_W-1:0]   w_data = '0;
  logic [DATA_W/8-1:0] w_strb = '0;
  logic                w_last = 1'b0;
  logic                w_valid = 1'b0;
  logic                b_ready = 1'b0;
  logic [ID_W-1:0]     ar_id = '0;
  logic [ADDR_W-1:0]   ar_addr = '0;
  logic [LEN_W-1:0]    ar_len = '0;
  logic [2:0]          ar_size = 3'd2;
  logic [1:0]          ar_burst = 2'b01;
  logic                ar_valid = 1'b0;
  logic                r_ready = 1'b0;

  // main instance outputs
  logic              aw_ready, w_ready, b_valid, ar_ready, r_last, r_valid;
  logic [ID_W-1:0]   b_id, r_id;
  logic [1:0]        b_resp, r_resp;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;

  // small-counter instance outputs (only the counters are examined)
  logic              unused_s_aw_ready, unused_s_w_ready, unused_s_b_valid;
  logic              unused_s_ar_ready, unused_s_r_last, unused_s_r_valid;
  logic [ID_W-1:0]   unused_s_b_id, unused_s_r_id;
  logic [1:0]        unused_s_b_resp, unused_s_r_resp;
  logic [DATA_W-1:0] unused_s_r_data;
  logic [SAT_W-1:0]  s_wr_cnt, s_rd_cnt;

  axi_default_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWID_S(aw_id), .AWADDR_S(aw_addr), .AWLEN_S(aw_len), .AWSIZE_S(aw_size),
    .AWBURST_S(aw_burst), .AWVALID_S(aw_valid), .AWREADY_S(aw_ready),
    .WDATA_S(w_data), .WSTRB_S(w_strb), .WLAST_S(w_last), .WVALID_S(w_valid),
    .WREADY_S(w_ready),
    .BID_S(b_id), .BRESP_S(b_resp), .BVALID_S(b_valid), .BREADY_S(b_ready),
    .ARID_S(ar_id), .ARADDR_S(ar_addr), .ARLEN_S(ar_len), .ARSIZE_S(ar_size),
    .ARBURST_S(ar_burst), .ARVALID_S(ar_valid), .ARREADY_S(ar_ready),
    .RID_S(r_id), .RDATA_S(r_data), .RRESP_S(r_resp), .RLAST_S(r_last),
    .RVALID_S(r_valid), .RREADY_S(r_ready),
    .wr_err_cnt(wr_cnt), .rd_err_cnt(rd_cnt)
  );

  axi_default_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .LEN_W(LEN_W), .CNT_W(SAT_W)) dut_sat (
    .ACLK(clk), .ARESETn(rst_n),
    .AWID_S(aw_id), .AWADDR_S(aw_addr), .AWLEN_S(aw_len), .AWSIZE_S(aw_size),
    .AWBURST_S(aw_burst), .AWVALID_S(aw_valid), .AWREADY_S(unused_s_aw_ready),
    .WDATA_S(w_data), .WSTRB_S(w_strb), .WLAST_S(w_last), .WVALID_S(w_valid),
    .WREADY_S(unused_s_w_ready),
    .BID_S(unused_s_b_id), .BRESP_S(unused_s_b_resp), .BVALID_S(unused_s_b_valid),
    .BREADY_S(b_ready),
    .ARID_S(ar_id), .ARADDR_S(ar_addr), .ARLEN_S(ar_len), .ARSIZE_S(ar_size),
    .ARBURST_S(ar_burst), .ARVALID_S(ar_valid), .ARREADY_S(unused_s_ar_ready),
    .RID_S(unused_s_r_id), .RDATA_S(unused_s_r_data), .RRESP_S(unused_s_r_resp),
    .RLAST_S(unused_s_r_last), .RVALID_S(unused_s_r_valid), .RREADY_S(r_ready),
    .wr_err_cnt(s_wr_cnt), .rd_err_cnt(s_rd_cnt)
  );

  int checks = 0;
  int failures = 0;
  int exp_wr = 0;   // completed write bursts since last reset
  int exp_rd = 0;   // completed read bursts since last reset

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int sat_of(input int n);
    return (n > SAT_MAX) ? SAT_MAX : n;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), exp_wr);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), exp_rd);
    check({tag, "_sat_wr_cnt"}, 32'(s_wr_cnt), sat_of(exp_wr));
    check({tag, "_sat_rd_cnt"}, 32'(s_rd_cnt), sat_of(exp_rd));
  endtask

  // One write burst. gaps inserts random idle cycles on W; bwait holds
  // BREADY low that many cycles while a competing AW is offered.
  task automatic do_write(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                          input int bwait, input bit gaps);
    int beats = 0;
    int guard = 0;
    int wr_high = 0;
    bit hs;
    check("aw_ready_idle", 32'(aw_ready), 1);
    check("w_ready_before_aw", 32'(w_ready), 0);
    // An early W beat rides alongside the address and must be ignored.
    aw_valid = 1'b1; aw_id = id; aw_len = len; aw_addr = $urandom;
    w_valid = 1'b1; w_last = 1'b1; w_data = $urandom;
    tick();
    aw_valid = 1'b0;
    check("aw_ready_after_aw", 32'(aw_ready), 0);
    while (int'(beats) <= int'(len) && guard < 200) begin
      w_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_last  = (beats == int'(len));
      w_data  = $urandom;
      w_strb  = 4'($urandom);
      if (w_ready) wr_high++;
      check("w_ready_data", 32'(w_ready), 1);
      check("b_valid_data", 32'(b_valid), 0);
      hs = w_valid && w_ready;
      tick();
      if (hs) beats++;
      guard++;
    end
    w_valid = 1'b0; w_last = 1'b0;
    if (guard >= 200) check("w_timeout", 0, 1);
    if (!gaps) check("w_ready_cycles", wr_high, int'(len) + 1);
    check("w_ready_after_last", 32'(w_ready), 0);
    check("b_valid", 32'(b_valid), 1);
    check("b_id", 32'(b_id), 32'(id));
    check("b_resp", 32'(b_resp), 3);
    for (int i = 0; i < bwait; i++) begin
      aw_valid = 1'b1; aw_id = ~id;
      tick();
      check("b_valid_hold", 32'(b_valid), 1);
      check("b_id_hold", 32'(b_id), 32'(id));
      check("b_resp_hold", 32'(b_resp), 3);
      check("aw_ready_during_b", 32'(aw_ready), 0);
    end
    aw_valid = 1'b0;
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    exp_wr++;
    check("b_valid_after_b", 32'(b_valid), 0);
    check("aw_ready_after_b", 32'(aw_ready), 1);
    check_counts("wr_done");
  endtask

  // One read burst. mode 0: random RREADY, 1: 1,0,1,0..., 2: held high.
  task automatic do_read(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len,
                         input int mode);
    int beats = 0;
    int cyc = 0;
    bit hs;
    check("ar_ready_idle", 32'(ar_ready), 1);
    ar_valid = 1'b1; ar_id = id; ar_len = len; ar_addr = $urandom;
    tick();
    ar_valid = 1'b0;
    check("ar_ready_after_ar", 32'(ar_ready), 0);
    while (beats <= int'(len) && cyc < 400) begin
      case (mode)
        1:       r_ready = ((cyc % 2) == 0);
        2:       r_ready = 1'b1;
        default: r_ready = $urandom_range(0, 1) != 0;
      endcase
      check("r_valid", 32'(r_valid), 1);
      check("r_id", 32'(r_id), 32'(id));
      check("r_data", r_data, 0);
      check("r_resp", 32'(r_resp), 3);
      check("r_last", 32'(r_last), 32'(beats == int'(len)));
      hs = r_ready && r_valid;
      tick();
      if (hs) beats++;
      cyc++;
    end
    r_ready = 1'b0;
    if (cyc >= 400) check("r_timeout", 0, 1);
    if (mode == 2) check("r_b2b_cycles", cyc, int'(len) + 1);
    exp_rd++;
    check("r_valid_after_last", 32'(r_valid), 0);
    check("ar_ready_after_last", 32'(ar_ready), 1);
    check_counts("rd_done");
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    check("rst_aw_ready", 32'(aw_ready), 0);
    check("rst_w_ready", 32'(w_ready), 0);
    check("rst_b_valid", 32'(b_valid), 0);
    check("rst_b_id", 32'(b_id), 0);
    check("rst_b_resp", 32'(b_resp), 0);
    check("rst_ar_ready", 32'(ar_ready), 0);
    check("rst_r_valid", 32'(r_valid), 0);
    check("rst_r_last", 32'(r_last), 0);
    check("rst_r_id", 32'(r_id), 0);
    check("rst_r_resp", 32'(r_resp), 0);
    check("rst_r_data", r_data, 0);
    check_counts("rst");
    rst_n = 1'b1;
    tick();
    check("post_rst_aw_ready", 32'(aw_ready), 1);
    check("post_rst_ar_ready", 32'(ar_ready), 1);
    check_counts("post_rst");

    // ---------------- directed bursts ----------------
    do_write(8'h12, 4'd3, 0, 1'b0);
    do_read(8'h05, 4'd7, 1);

    // concurrent single-beat write and read
    check("cc_aw_ready", 32'(aw_ready), 1);
    check("cc_ar_ready", 32'(ar_ready), 1);
    aw_valid = 1'b1; aw_id = 8'hA1; aw_len = '0;
    ar_valid = 1'b1; ar_id = 8'hB2; ar_len = '0;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    check("cc_w_ready", 32'(w_ready), 1);
    check("cc_r_valid", 32'(r_valid), 1);
    check("cc_r_last", 32'(r_last), 1);
    check("cc_r_id", 32'(r_id), 32'h B2);
    w_valid = 1'b1; w_last = 1'b1; r_ready = 1'b1; b_ready = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0; r_ready = 1'b0;
    exp_rd++;
    check("cc_b_valid", 32'(b_valid), 1);
    check("cc_b_id", 32'(b_id), 32'h A1);
    check("cc_r_valid_done", 32'(r_valid), 0);
    check("cc_ar_ready_done", 32'(ar_ready), 1);
    tick();
    b_ready = 1'b0;
    exp_wr++;
    check("cc_b_valid_done", 32'(b_valid), 0);
    check("cc_aw_ready_done", 32'(aw_ready), 1);
    check_counts("cc");

    // B back-pressure for 10 cycles with a competing AW offered
    do_write(8'h3C, 4'd1, 10, 1'b1);

    // length boundaries, back-to-back
    do_read(8'h77, 4'd15, 2);
    do_read(8'h78, 4'd0, 2);

    // ---------------- randomized bursts ----------------
    for (int i = 0; i < 12; i++) begin
      do_write(8'($urandom), 4'($urandom), $urandom_range(0, 3), 1'b1);
      do_read(8'($urandom), 4'($urandom), $urandom_range(0, 2));
    end

    // ---------------- reset in the middle of a read ----------------
    ar_valid = 1'b1; ar_id = 8'h99; ar_len = 4'd15;
    tick();
    ar_valid = 1'b0;
    r_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_wr = 0;
    exp_rd = 0;
    check("mid_rst_r_valid", 32'(r_valid), 0);
    check("mid_rst_ar_ready", 32'(ar_ready), 0);
    check_counts("mid_rst");
    r_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_rst_ar_ready_after", 32'(ar_ready), 1);
    check("mid_rst_aw_ready_after", 32'(aw_ready), 1);
    check_counts("mid_rst_after");

    // ---------------- saturation on the small-counter instance ----------------
    for (int i = 0; i < SAT_MAX + 3; i++) begin
      do_write(8'($urandom), 4'd0, 0, 1'b0);
      do_read(8'($urandom), 4'd0, 2);
    end
    check("sat_wr_held", 32'(s_wr_cnt), SAT_MAX);
    check("sat_rd_held", 32'(s_rd_cnt), SAT_MAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
